// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, widths and reset defaults.
package fetch_unit_pkg;

   localparam int unsigned InstrWidth     = 32;
   localparam int unsigned EntryWidth     = 2 * InstrWidth;
   localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StHalt  = 2'd1,
      StFault = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction memory port, decode handshake, redirect/halt control and fault flag.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic [31:0]           im_addr;
   logic [InstrWidth-1:0] im_data;
   logic                  id_ready;
   logic                  if_valid;
   logic [InstrWidth-1:0] if_instr;
   logic [31:0]           if_pc;
   logic                  redirect_valid;
   logic [31:0]           redirect_pc;
   logic                  halt_req;
   logic                  if_fault;

   modport master (
      output im_addr, if_valid, if_instr, if_pc, if_fault,
      input  im_data, id_ready, redirect_valid, redirect_pc, halt_req
   );

   modport slave (
      input  im_addr, if_valid, if_instr, if_pc, if_fault,
      output im_data, id_ready, redirect_valid, redirect_pc, halt_req
   );

endinterface

// File: rtl/fetch_buffer.sv
// DEPTH-entry synchronous FIFO holding {pc, instr} pairs; flush empties it in one cycle.
module fetch_buffer #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head_data
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   // A pop frees the slot in the same cycle, so a full buffer can still accept a push.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (!do_push && do_pop) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks the PC through instruction memory into a small buffer feeding decode.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DefaultResetPc,
   parameter int unsigned IM_WORDS = 32,
   parameter int unsigned DEPTH    = 2
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   fetch_state_e          state_q;
   logic [31:0]           pc_q;
   logic                  fault_q;
   logic                  full, empty;
   logic                  pc_oob, flush, pop, push;
   logic [EntryWidth-1:0] head;

   assign pc_oob = ({2'b00, pc_q[31:2]} >= IM_WORDS);
   assign flush  = bus.redirect_valid;
   assign pop    = !empty && bus.id_ready && !flush;
   assign push   = (state_q == StRun) && !flush && !bus.halt_req && !pc_oob && (!full || pop);

   fetch_buffer #(
      .DEPTH (DEPTH),
      .WIDTH (EntryWidth)
   ) u_fetch_buffer (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .push_data ({pc_q, bus.im_data}),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .head_data (head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         state_q <= StRun;
         fault_q <= 1'b0;
      end else if (bus.redirect_valid) begin
         pc_q    <= {bus.redirect_pc[31:2], 2'b00};
         state_q <= StRun;
         fault_q <= 1'b0;
      end else if (state_q == StRun) begin
         if (bus.halt_req) begin
            state_q <= StHalt;
         end else if (pc_oob) begin
            state_q <= StFault;
            fault_q <= 1'b1;
         end else if (push) begin
            pc_q <= pc_q + 32'd4;
         end
      end
   end

   assign bus.im_addr  = {2'b00, pc_q[31:2]};
   assign bus.if_valid = !empty;
   assign bus.if_instr = head[InstrWidth-1:0];
   assign bus.if_pc    = head[EntryWidth-1:InstrWidth];
   assign bus.if_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences and a random run
// checked every cycle against a queue-based reference model.
module tb_fetch_unit;

   localparam int unsigned IM_WORDS = 32;
   localparam int unsigned DEPTH    = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .IM_WORDS (IM_WORDS),
      .DEPTH    (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [31:0] idx);
      case (idx)
         32'd0:   return 32'h8D88_0000;
         32'd1:   return 32'h8D89_0004;
         32'd2:   return 32'h0128_5020;
         32'd3:   return 32'hAD8A_0008;
         default: return 32'hA000_0000 + idx;
      endcase
   endfunction

   assign bus.im_data = imem_word(bus.im_addr);

   // Reference model: a queue of fetched entries plus the fetch pointer and a mode.
   logic [31:0] m_pc_q[$];
   logic [31:0] m_in_q[$];
   logic [31:0] m_pc;
   int          m_mode;  // 0 fetching, 1 halted, 2 faulted
   logic        m_fault;

   task automatic model_step(input logic r, input logic rdy, input logic rv,
                             input logic [31:0] rpc, input logic hr);
      bit popped;
      if (r) begin
         m_pc_q.delete(); m_in_q.delete();
         m_pc = 32'h0; m_mode = 0; m_fault = 1'b0;
      end else if (rv) begin
         m_pc_q.delete(); m_in_q.delete();
         m_pc = rpc & ~32'h3; m_mode = 0; m_fault = 1'b0;
      end else begin
         popped = (m_pc_q.size() > 0) && rdy;
         if (m_mode == 0) begin
            if (hr) begin
               m_mode = 1;
            end else if ((m_pc / 4) >= IM_WORDS) begin
               m_mode = 2; m_fault = 1'b1;
            end else if ((m_pc_q.size() - (popped ? 1 : 0)) < DEPTH) begin
               m_pc_q.push_back(m_pc);
               m_in_q.push_back(imem_word(m_pc / 4));
               m_pc = m_pc + 32'd4;
            end
         end
         if (popped) begin
            void'(m_pc_q.pop_front());
            void'(m_in_q.pop_front());
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_compare();
      chk("model_valid", 32'(bus.if_valid), 32'(m_pc_q.size() > 0));
      if (m_pc_q.size() > 0) begin
         chk("model_pc", bus.if_pc, m_pc_q[0]);
         chk("model_instr", bus.if_instr, m_in_q[0]);
      end
      chk("model_addr", bus.im_addr, m_pc >> 2);
      chk("model_fault", 32'(bus.if_fault), 32'(m_fault));
   endtask

   // One clock: drive inputs, advance the model, sample #1 after the edge.
   task automatic step(input logic r, input logic rdy, input logic rv,
                       input logic [31:0] rpc, input logic hr);
      rst = r;
      bus.id_ready = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc = rpc;
      bus.halt_req = hr;
      model_step(r, rdy, rv, rpc, hr);
      @(posedge clk);
      #1;
      model_compare();
   endtask

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        hr;
      logic        exp_valid;
      logic        chk_data;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      logic [31:0] exp_addr;
      logic        exp_fault;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                               input logic [31:0] rpc, input logic ev, input logic cd,
                               input logic [31:0] epc, input logic [31:0] ein,
                               input logic [31:0] ea);
      vec_t v;
      v.rst = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hr = 1'b0;
      v.exp_valid = ev; v.chk_data = cd; v.exp_pc = epc; v.exp_instr = ein;
      v.exp_addr = ea; v.exp_fault = 1'b0;
      return v;
   endfunction

   vec_t vecs[10];

   initial begin
      rst = 1'b1;
      bus.id_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.halt_req = 1'b0;

      // Reset, streaming 0..C, fill to full, then redirect to a misaligned PC while full.
      vecs[0] = mk(1, 0, 0, 0,     0, 1, 32'h00, 32'h0,         32'd0);
      vecs[1] = mk(1, 1, 0, 0,     0, 1, 32'h00, 32'h0,         32'd0);
      vecs[2] = mk(0, 1, 0, 0,     1, 1, 32'h00, 32'h8D88_0000, 32'd1);
      vecs[3] = mk(0, 1, 0, 0,     1, 1, 32'h04, 32'h8D89_0004, 32'd2);
      vecs[4] = mk(0, 1, 0, 0,     1, 1, 32'h08, 32'h0128_5020, 32'd3);
      vecs[5] = mk(0, 1, 0, 0,     1, 1, 32'h0C, 32'hAD8A_0008, 32'd4);
      vecs[6] = mk(0, 0, 0, 0,     1, 1, 32'h0C, 32'hAD8A_0008, 32'd5);
      vecs[7] = mk(0, 0, 0, 0,     1, 1, 32'h0C, 32'hAD8A_0008, 32'd5);
      vecs[8] = mk(0, 0, 1, 32'hE, 0, 0, 32'h00, 32'h0,         32'd3);
      vecs[9] = mk(0, 0, 0, 0,     1, 1, 32'h0C, 32'hAD8A_0008, 32'd4);

      for (int i = 0; i < 10; i++) begin
         step(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rpc, vecs[i].hr);
         chk($sformatf("tbl%0d_valid", i), 32'(bus.if_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("tbl%0d_addr", i), bus.im_addr, vecs[i].exp_addr);
         chk($sformatf("tbl%0d_fault", i), 32'(bus.if_fault), 32'(vecs[i].exp_fault));
         if (vecs[i].chk_data) begin
            chk($sformatf("tbl%0d_pc", i), bus.if_pc, vecs[i].exp_pc);
            chk($sformatf("tbl%0d_instr", i), bus.if_instr, vecs[i].exp_instr);
         end
      end

      // Decode stalled after reset: two entries held, pc parked at 8, then in-order release.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
      chk("stall_addr", bus.im_addr, 32'd2);
      chk("stall_head", bus.if_pc, 32'h0);
      step(0, 1, 0, 0, 0);
      chk("release_1", bus.if_pc, 32'h4);
      step(0, 1, 0, 0, 0);
      chk("release_2", bus.if_pc, 32'h8);
      step(0, 1, 0, 0, 0);
      chk("release_3", bus.if_pc, 32'hC);

      // Running off the end of instruction memory.
      step(0, 1, 1, 32'h78, 0);
      step(0, 1, 0, 0, 0);
      chk("end_pc78", bus.if_pc, 32'h78);
      step(0, 1, 0, 0, 0);
      chk("end_pc7c", bus.if_pc, 32'h7C);
      step(0, 1, 0, 0, 0);
      chk("end_fault", 32'(bus.if_fault), 32'd1);
      chk("end_empty", 32'(bus.if_valid), 32'd0);
      step(0, 1, 0, 0, 0);
      chk("end_sticky", 32'(bus.if_fault), 32'd1);
      step(0, 1, 1, 32'h0, 0);
      chk("end_clear", 32'(bus.if_fault), 32'd0);
      step(0, 0, 0, 0, 0);
      chk("end_restart", bus.if_pc, 32'h0);

      // Halt with one entry buffered, then redirect and halt together.
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("halt_addr", bus.im_addr, 32'd1);
      chk("halt_head", bus.if_pc, 32'h0);
      step(0, 1, 0, 0, 0);
      chk("halt_drained", 32'(bus.if_valid), 32'd0);
      step(0, 1, 0, 0, 0);
      chk("halt_nopush", 32'(bus.if_valid), 32'd0);
      step(0, 0, 1, 32'h8, 1);
      step(0, 0, 0, 0, 0);
      chk("halt_redirect", bus.if_pc, 32'h8);

      // Reset mid-stream with a full buffer.
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 1, 1, 32'h40, 1);
      chk("rst_valid", 32'(bus.if_valid), 32'd0);
      chk("rst_addr", bus.im_addr, 32'd0);
      chk("rst_fault", 32'(bus.if_fault), 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 15) == 0), 32'($urandom_range(0, 32'h9F)),
              ($urandom_range(0, 19) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter IM_WORDS, default 32, number of valid instruction-memory words.
REQ-003 Parameter DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 im_addr  out  32  word index to instruction memory = {2'b00, pc[31:2]}.
REQ-007 im_data  in  32  instruction word returned combinationally for im_addr in the same cycle.
REQ-008 id_ready  in  1  decode accepts the head entry this cycle.
REQ-009 if_valid  out  1  head entry present.
REQ-010 if_instr  out  32  head entry instruction.
REQ-011 if_pc  out  32  head entry byte PC.
REQ-012 redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-013 redirect_pc  in  32  new byte PC; bits [1:0] forced to 0.
REQ-014 halt_req  in  1  stop fetching; buffer drains.
REQ-015 if_fault  out  1  sticky: PC word index >= IM_WORDS.

Function
REQ-016 FSM states RUN, HALT, FAULT; encoding 2 bits.
REQ-017 RUN: push {pc, im_data} when buffer not full or pop occurs this cycle, pc <= pc+4 (32-bit wrap); no push otherwise, pc holds.
REQ-018 Pop when if_valid && id_ready; head advances next cycle; if_valid/if_instr/if_pc driven from buffer registers only (no combinational path from im_data).
REQ-019 Fetch-to-if_valid latency: 1 cycle (push at edge N, visible after edge N).
REQ-020 Simultaneous push and pop when full: both occur, count unchanged.
REQ-021 Buffer pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-022 redirect_valid (any state): buffer flushed (count 0, no push, no pop credited), pc <= {redirect_pc[31:2],2'b00}, state <= RUN, if_fault <= 0; if_valid low next cycle.
REQ-023 redirect_valid has priority over halt_req, push, pop and fault detection in the same cycle.
REQ-024 halt_req in RUN without redirect: no push that cycle, state <= HALT; pops continue.
REQ-025 HALT: no pushes, pc holds; exit only via redirect or reset.
REQ-026 RUN with pc[31:2] >= IM_WORDS: no push, state <= FAULT, if_fault <= 1; buffer drains normally.
REQ-027 FAULT: no pushes; exit only via redirect or reset.
REQ-028 im_addr continuously reflects current pc in all states.

Reset
REQ-029 rst high at an edge: pc <= RESET_PC, state <= RUN, buffer count and pointers 0, if_fault <= 0.
REQ-030 During/after reset: if_valid=0, if_instr=0, if_pc=0 (entry storage cleared); first push on the first edge with rst low.
REQ-031 rst overrides redirect_valid, halt_req and id_ready mid-operation.

Structure
REQ-032 Shared package holds FSM state constants, RESET_PC default and instruction width (32).
REQ-033 One sub-module fetch_buffer (DEPTH-entry synchronous FIFO, 64-bit entries, push/pop/flush, full/empty) instantiated once.

Verification
REQ-034 IM words 0..3 = 8D880000, 8D890004, 01285020, AD8A0008; reset, id_ready=1 -> if_pc 0,4,8,C on consecutive cycles from first cycle after reset release, if_instr matching.
REQ-035 id_ready=0 for 5 cycles after reset -> buffer holds PC 0,4; pc stays 8; release -> PC 0,4,8 delivered in order, none lost or duplicated.
REQ-036 redirect_valid with redirect_pc=32'h0000_000E while buffer full -> next cycle if_valid=0, following cycle if_pc=C, if_instr=AD8A0008.
REQ-037 Run from pc 0x78 with id_ready=1 -> entries 0x78,0x7C delivered, then if_fault=1, if_valid=0; redirect to 0 clears fault and delivers PC 0.
REQ-038 halt_req pulse with id_ready=0 and 1 entry buffered -> no further pushes; entry still delivered when id_ready=1; redirect and halt_req same cycle -> RUN at redirect_pc.
REQ-039 rst asserted mid-stream with full buffer -> next cycle if_valid=0, im_addr=0, if_fault=0.
